// File: rtl/controle_pkg.sv
// Shared encodings for the instruction sequencer: opcodes, ALU operations,
// FSM states and the instruction-width helper.
package controle_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_MV   = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_ILL  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_LOAD_A,
        S_EXEC,
        S_WRITE,
        S_MOVE,
        S_OUTP
    } state_t;

    function automatic int iw(input int reg_addr_w);
        return 3 + 2 * reg_addr_w;
    endfunction

    function automatic logic [1:0] alu_of(input logic [2:0] opcode);
        case (opcode)
            OP_SUB:  return ALU_SUB;
            OP_NAND: return ALU_NAND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/controle_sequencial_if.sv
// Issue port and datapath control strobes of the sequencer; the sequencer
// takes the slave side, whoever issues instructions takes the master side.
interface controle_sequencial_if
    import controle_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
) ();

    localparam int IW   = iw(REG_ADDR_W);
    localparam int NREG = 2 ** REG_ADDR_W;

    logic              run;
    logic [IW-1:0]     instr;
    logic [NREG-1:0]   reg_select;
    logic              imm_select;
    logic [DATA_W-1:0] imm;
    logic              r_select;
    logic              a_enable;
    logic              r_enable;
    logic [1:0]        alu_op;
    logic [NREG-1:0]   reg_enable;
    logic              out_enable;
    logic              busy;
    logic              done;
    logic              illegal;

    modport master (
        output run, instr,
        input  reg_select, imm_select, imm, r_select, a_enable, r_enable,
               alu_op, reg_enable, out_enable, busy, done, illegal
    );

    modport slave (
        input  run, instr,
        output reg_select, imm_select, imm, r_select, a_enable, r_enable,
               alu_op, reg_enable, out_enable, busy, done, illegal
    );

endinterface

// File: rtl/decodificador_param.sv
// Binary-to-one-hot decoder: N-bit index in, 2**N-bit one-hot out.
module decodificador_param #(
    parameter int N = 3
) (
    input  logic [N-1:0]      bin,
    output logic [2**N-1:0]   onehot
);

    // NOTE: assign a default before the indexed write so no bit is left
    // unassigned on any path; otherwise a latch is inferred.
    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/controle_sequencial.sv
// Instruction sequencer: latches one instruction per run request, steps its
// own FSM and drives registered datapath control strobes.
module controle_sequencial
    import controle_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
) (
    input  logic clk,
    input  logic resetn,
    controle_sequencial_if.slave bus
);

    localparam int IW   = iw(REG_ADDR_W);
    localparam int NREG = 2 ** REG_ADDR_W;

    state_t                state;
    state_t                state_next;
    logic [IW-1:0]         ir;
    logic [IW-1:0]         ir_next;
    logic [2:0]            op;
    logic [2:0]            op_next;
    logic [REG_ADDR_W-1:0] rx_next;
    logic [REG_ADDR_W-1:0] ry_next;
    logic                  final_step;
    logic                  capture;
    logic [NREG-1:0]       rx_read_oh;
    logic [NREG-1:0]       ry_read_oh;
    logic [NREG-1:0]       rx_write_oh;

    assign op      = ir[IW-1 -: 3];
    assign op_next = ir_next[IW-1 -: 3];
    assign rx_next = ir_next[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ry_next = ir_next[REG_ADDR_W-1:0];

    always_comb begin
        final_step = 1'b0;
        case (state)
            S_DECODE:                final_step = (op == OP_NOP) || (op == OP_ILL);
            S_WRITE, S_MOVE, S_OUTP: final_step = 1'b1;
            default:                 final_step = 1'b0;
        endcase
    end

    assign capture = bus.run && ((state == S_IDLE) || final_step);
    assign ir_next = capture ? bus.instr : ir;

    always_comb begin
        state_next = state;
        if (capture) begin
            state_next = S_DECODE;
        end else if (final_step) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_DECODE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_NAND: state_next = S_LOAD_A;
                        OP_MV, OP_LDI:           state_next = S_MOVE;
                        OP_OUT:                  state_next = S_OUTP;
                        default:                 state_next = S_IDLE;
                    endcase
                end
                S_LOAD_A: state_next = S_EXEC;
                S_EXEC:   state_next = S_WRITE;
                default:  state_next = state;
            endcase
        end
    end

    // Decoders look at the instruction being entered so the strobes can be
    // registered alongside the state they belong to.
    decodificador_param #(.N(REG_ADDR_W)) u_dec_rx_read (
        .bin    (rx_next),
        .onehot (rx_read_oh)
    );

    decodificador_param #(.N(REG_ADDR_W)) u_dec_ry_read (
        .bin    (ry_next),
        .onehot (ry_read_oh)
    );

    decodificador_param #(.N(REG_ADDR_W)) u_dec_rx_write (
        .bin    (rx_next),
        .onehot (rx_write_oh)
    );

    // NOTE: every strobe is a flop cleared by the asynchronous reset, so no
    // write enable can glitch while reset is asserted or as it is released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            ir             <= '0;
            bus.reg_select <= '0;
            bus.imm_select <= 1'b0;
            bus.imm        <= '0;
            bus.r_select   <= 1'b0;
            bus.a_enable   <= 1'b0;
            bus.r_enable   <= 1'b0;
            bus.alu_op     <= ALU_ADD;
            bus.reg_enable <= '0;
            bus.out_enable <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.illegal    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked logic; later writes
            // below override these defaults within the same edge.
            state          <= state_next;
            ir             <= ir_next;
            bus.busy       <= (state_next != S_IDLE);
            bus.reg_select <= '0;
            bus.imm_select <= 1'b0;
            bus.imm        <= '0;
            bus.r_select   <= 1'b0;
            bus.a_enable   <= 1'b0;
            bus.r_enable   <= 1'b0;
            bus.alu_op     <= ALU_ADD;
            bus.reg_enable <= '0;
            bus.out_enable <= 1'b0;
            bus.done       <= 1'b0;
            bus.illegal    <= 1'b0;
            case (state_next)
                S_DECODE: begin
                    if ((op_next == OP_NOP) || (op_next == OP_ILL)) begin
                        bus.done    <= 1'b1;
                        bus.illegal <= (op_next == OP_ILL);
                    end
                end
                S_LOAD_A: begin
                    bus.reg_select <= rx_read_oh;
                    bus.a_enable   <= 1'b1;
                end
                S_EXEC: begin
                    bus.reg_select <= ry_read_oh;
                    bus.r_enable   <= 1'b1;
                    bus.alu_op     <= alu_of(op_next);
                end
                S_WRITE: begin
                    bus.r_select   <= 1'b1;
                    bus.reg_enable <= rx_write_oh;
                    bus.done       <= 1'b1;
                end
                S_MOVE: begin
                    if (op_next == OP_LDI) begin
                        bus.imm_select <= 1'b1;
                        bus.imm        <= DATA_W'(ry_next);
                    end else begin
                        bus.reg_select <= ry_read_oh;
                    end
                    bus.reg_enable <= rx_write_oh;
                    bus.done       <= 1'b1;
                end
                S_OUTP: begin
                    bus.reg_select <= rx_read_oh;
                    bus.out_enable <= 1'b1;
                    bus.done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/controle_sequencial.md
# controle_sequencial

Parametrised instruction sequencer for the register-file datapath. It latches one instruction per `run` request, walks its own step state machine, and drives the datapath control strobes: bus source select, A/R register loads, ALU operation, register write enables and output strobe. Execution length is variable per opcode, and back-to-back issue needs no idle bubble. It replaces an externally counted step input with an internal FSM and generalises register count and data width.

## Interface
- `REG_ADDR_W`, default 3: register address width. NREG = 2**REG_ADDR_W registers. Instruction width IW = 3 + 2*REG_ADDR_W.
- `DATA_W`, default 16: datapath width, used only for the immediate output.
- `clk` input, 1: single clock, rising edge.
- `resetn` input, 1: asynchronous, active-low reset.
- `run` input, 1: issue request. Sampled in IDLE or in any final step.
- `instr` input, IW: `{opcode[2:0], rx[REG_ADDR_W-1:0], ry[REG_ADDR_W-1:0]}`. Captured with `run`.
- `reg_select` output, NREG: one-hot bus read select. Bit i selects register i.
- `imm_select` output, 1: `imm` drives the bus.
- `imm` output, DATA_W: zero-extended `ry` field of the latched instruction.
- `r_select` output, 1: R register drives the bus.
- `a_enable` output, 1: load A from the bus.
- `r_enable` output, 1: load R with the ALU result.
- `alu_op` output, 2: 00 ADD, 01 SUB, 10 NAND.
- `reg_enable` output, NREG: one-hot register write enable.
- `out_enable` output, 1: load the output port from the bus.
- `busy` output, 1: high whenever the state is not IDLE.
- `done` output, 1: one-cycle strobe in the final step of each instruction.
- `illegal` output, 1: strobe coincident with `done` for opcode 110.

## Operation
- Opcodes:
  - 000 ADD rx←rx+ry
  - 001 SUB rx←rx−ry
  - 010 NAND
  - 011 MV rx←ry
  - 100 OUT port←rx
  - 101 LDI rx←imm
  - 110 illegal
  - 111 NOP
- States: IDLE, DECODE, LOAD_A, EXEC, WRITE, MOVE, OUTP.
- Outputs are a function of state and the latched instruction register `ir` only; they never depend on `instr` directly. Any output not listed for a state is 0.
- IDLE: all outputs 0. On `run`=1, `ir`←`instr` and go to DECODE.
- DECODE: next state by opcode.
  - ALU opcodes → LOAD_A.
  - MV, LDI → MOVE.
  - OUT → OUTP.
  - NOP and illegal: assert `done` (plus `illegal` for 110) here; this is their final step.
- LOAD_A: `reg_select`=onehot(rx), `a_enable`=1 → EXEC.
- EXEC: `reg_select`=onehot(ry), `r_enable`=1, `alu_op` from opcode → WRITE.
- WRITE: `r_select`=1, `reg_enable`=onehot(rx), `done`=1.
- MOVE:
  - MV: `reg_select`=onehot(ry).
  - LDI: `imm_select`=1, `reg_select`=0.
  - Both: `reg_enable`=onehot(rx), `done`=1.
- OUTP: `reg_select`=onehot(rx), `out_enable`=1, `done`=1.
- Final step (any state with `done`=1):
  - `run`=1 → capture the new `instr` into `ir` and go to DECODE.
  - `run`=0 → go to IDLE.
- `run` in any non-final, non-IDLE state is ignored. No queueing.
- Invariants:
  - `reg_select` is 0 or one-hot.
  - `imm_select`, `r_select` and `reg_select`≠0 are mutually exclusive.
  - `reg_enable` is nonzero only when `done`=1.
- Reset (asynchronous, any time, including mid-instruction): state←IDLE, `ir`←0, all outputs 0. No write enable may glitch high during or on release of reset.

## Timing
- Cycle 0 is the `run` sample edge. Final step, and `done`, occurs in:
  - NOP/illegal: cycle 1.
  - MV/LDI/OUT: cycle 2.
  - ADD/SUB/NAND: cycle 4.
- Issue rate with `run` held high:
  - ALU: 1 instruction per 4 cycles.
  - MV/LDI/OUT: 1 per 2 cycles.
  - NOP: 1 per cycle.
- `busy` rises in cycle 1. It falls in the cycle after the final step only if `run`=0.
- The datapath samples enables on the same edge that ends the step; `ir` is stable from DECODE through the final step.

## Structure
- Package `controle_pkg`:
  - opcode localparams;
  - `alu_op` encodings;
  - state enum typedef;
  - function `iw(REG_ADDR_W)`.
- One sub-module: `decodificador_param` (parameter `N`, binary N → one-hot 2**N), instantiated three times: rx read, ry read, rx write.
- FSM and `ir` live in the top.

## Test plan
- Reset and idle: `resetn`=0 mid-EXEC of ADD → all outputs 0 immediately, state IDLE; `busy`=0 after release.
- ADD R2,R5 (`instr`=9'h015), REG_ADDR_W=3:
  - cycle 2: `reg_select`=8'h04, `a_enable`=1.
  - cycle 3: `reg_select`=8'h20, `alu_op`=00.
  - cycle 4: `reg_enable`=8'h04, `r_select`=1, `done`=1.
- Back-to-back, `run` held: SUB R7,R0 (9'h078) then LDI R3,#6 (9'h15E):
  - SUB: `alu_op`=01 at cycle 3, `done` at cycle 4.
  - LDI: `imm`=16'h0006, `imm_select`=1, `reg_enable`=8'h08 at cycle 6.
  - `busy` stays high throughout.
- MV R1,R6 (9'h0CE) → cycle 2: `reg_select`=8'h40, `reg_enable`=8'h02, `done`=1.
- OUT R4 (9'h120) → cycle 2: `reg_select`=8'h10, `out_enable`=1, `reg_enable`=0.
- Illegal opcode (9'h180) → cycle 1: `done`=1, `illegal`=1, no enables. `run` pulsed during an ALU EXEC is ignored. REG_ADDR_W=4 rerun of the ADD case gives a 16-bit one-hot.
